// File: rtl/mig_reset_sequencer_pkg.sv
// rtl/mig_reset_sequencer_pkg.sv - shared state encodings and default timing for the MIG reset sequencer
package mig_reset_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_CALIB = 3'd2,
    ST_READY = 3'd3,
    ST_ERROR = 3'd4
  } mig_seq_state_t;

  // Defaults assume a 100 MHz i_Clock: 200 us hold, 100 ms calibration limit
  localparam int DEF_COUNTER_WIDTH        = 24;
  localparam int DEF_HOLD_CYCLES          = 20000;
  localparam int DEF_CALIB_TIMEOUT_CYCLES = 10000000;
  localparam int DEF_MAX_RETRIES          = 3;

endpackage

// File: rtl/mig_reset_sequencer.sv
// rtl/mig_reset_sequencer.sv - MIG reset hold, calibration wait, retry and error sequencing
module mig_reset_sequencer
  import mig_reset_sequencer_pkg::*;
#(
  parameter int COUNTER_WIDTH        = DEF_COUNTER_WIDTH,
  parameter int HOLD_CYCLES          = DEF_HOLD_CYCLES,
  parameter int CALIB_TIMEOUT_CYCLES = DEF_CALIB_TIMEOUT_CYCLES,
  parameter int MAX_RETRIES          = DEF_MAX_RETRIES
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Clk_Locked,
  input  logic       i_Calib_Complete,
  output logic       o_Mig_Reset,
  output logic       o_System_Reset,
  output logic       o_Ready,
  output logic       o_Error,
  output logic [1:0] o_Retry_Count,
  output logic [2:0] o_State
);

  localparam int MAX_CYC = (HOLD_CYCLES > CALIB_TIMEOUT_CYCLES) ? HOLD_CYCLES : CALIB_TIMEOUT_CYCLES;
  localparam logic [COUNTER_WIDTH-1:0] HOLD_LAST  = COUNTER_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] CALIB_LAST = COUNTER_WIDTH'(CALIB_TIMEOUT_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_SAT    = '1;
  localparam logic [1:0]               RETRY_MAX  = 2'(MAX_RETRIES);

  // The shared counter must be able to represent the longest interval
  if ((64'd1 << COUNTER_WIDTH) <= 64'(MAX_CYC)) begin : g_width_check
    $error("COUNTER_WIDTH too small for HOLD_CYCLES / CALIB_TIMEOUT_CYCLES");
  end

  // Flops power up at their reset values
  mig_seq_state_t           state_q   = ST_IDLE;
  logic [COUNTER_WIDTH-1:0] cnt_q     = '0;
  logic [1:0]               retry_q   = 2'd0;
  logic                     mig_rst_q = 1'b0;
  logic                     sys_rst_q = 1'b1;
  logic                     ready_q   = 1'b0;
  logic                     error_q   = 1'b0;

  mig_seq_state_t           state_d;
  logic [COUNTER_WIDTH-1:0] cnt_d;
  logic [1:0]               retry_d;
  logic                     mig_rst_d;
  logic                     sys_rst_d;
  logic                     ready_d;
  logic                     error_d;
  logic [COUNTER_WIDTH-1:0] cnt_inc;
  logic                     go_idle;
  logic                     go_fail;

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    mig_rst_d = mig_rst_q;
    sys_rst_d = sys_rst_q;
    ready_d   = ready_q;
    error_d   = error_q;
    go_idle   = 1'b0;
    go_fail   = 1'b0;
    cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (i_Clk_Locked) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (!i_Clk_Locked) begin
          go_idle = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d   = ST_CALIB;
          cnt_d     = '0;
          mig_rst_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_CALIB: begin
        // Completion is tested before the timeout so it wins a tie
        if (!i_Clk_Locked) begin
          go_idle = 1'b1;
        end else if (i_Calib_Complete) begin
          state_d   = ST_READY;
          cnt_d     = '0;
          sys_rst_d = 1'b0;
          ready_d   = 1'b1;
        end else if (cnt_q == CALIB_LAST) begin
          go_fail = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_READY: begin
        if (!i_Clk_Locked) begin
          go_idle = 1'b1;
        end else if (!i_Calib_Complete) begin
          go_fail = 1'b1;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase

    // Calibration lost or timed out: re-hold while retries remain, else give up
    if (go_fail) begin
      cnt_d     = '0;
      mig_rst_d = 1'b0;
      sys_rst_d = 1'b1;
      ready_d   = 1'b0;
      if (retry_q < RETRY_MAX) begin
        state_d = ST_HOLD;
        retry_d = retry_q + 2'd1;
      end else begin
        state_d = ST_ERROR;
        error_d = 1'b1;
      end
    end

    if (go_idle || i_Reset) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      retry_d   = 2'd0;
      mig_rst_d = 1'b0;
      sys_rst_d = 1'b1;
      ready_d   = 1'b0;
      error_d   = 1'b0;
    end
  end

  // State, counters and outputs register
  always_ff @(posedge i_Clock) begin
    state_q   <= state_d;
    cnt_q     <= cnt_d;
    retry_q   <= retry_d;
    mig_rst_q <= mig_rst_d;
    sys_rst_q <= sys_rst_d;
    ready_q   <= ready_d;
    error_q   <= error_d;
  end

  assign o_Mig_Reset    = mig_rst_q;
  assign o_System_Reset = sys_rst_q;
  assign o_Ready        = ready_q;
  assign o_Error        = error_q;
  assign o_Retry_Count  = retry_q;
  assign o_State        = state_q;

endmodule

// File: tb/tb_mig_reset_sequencer.sv
// tb/tb_mig_reset_sequencer.sv - scoreboard bench for the MIG reset sequencer
module tb_mig_reset_sequencer;

  localparam int H = 8;
  localparam int T = 16;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lock = 1'b0;
  logic       calib = 1'b0;
  logic       mig_rst, sys_rst, ready, error;
  logic [1:0] retry;
  logic [2:0] state;

  int vec_cnt = 0;
  int miscompare_cnt = 0;

  logic [8:0] exp_q[$];

  // Reference model: phase, elapsed cycles in phase, retries
  int m_state = 0;
  int m_cnt   = 0;
  int m_retry = 0;

  mig_reset_sequencer #(
    .COUNTER_WIDTH(5),
    .HOLD_CYCLES(H),
    .CALIB_TIMEOUT_CYCLES(T),
    .MAX_RETRIES(R)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .i_Clk_Locked(lock),
    .i_Calib_Complete(calib),
    .o_Mig_Reset(mig_rst),
    .o_System_Reset(sys_rst),
    .o_Ready(ready),
    .o_Error(error),
    .o_Retry_Count(retry),
    .o_State(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_outputs();
    logic m, s, rd, e;
    m  = (m_state == 2) || (m_state == 3);
    s  = (m_state != 3);
    rd = (m_state == 3);
    e  = (m_state == 4);
    return {m, s, rd, e, 2'(m_retry), 3'(m_state)};
  endfunction

  task automatic model_fail();
    m_cnt = 0;
    if (m_retry < R) begin
      m_retry++;
      m_state = 1;
    end else begin
      m_state = 4;
    end
  endtask

  task automatic model_edge(input logic r, input logic l, input logic c);
    if (r) begin
      m_state = 0; m_cnt = 0; m_retry = 0;
    end else begin
      case (m_state)
        0: if (l) begin m_state = 1; m_cnt = 0; end
        1: if (!l) begin m_state = 0; m_retry = 0; end
           else if (m_cnt == H - 1) begin m_state = 2; m_cnt = 0; end
           else m_cnt++;
        2: if (!l) begin m_state = 0; m_retry = 0; end
           else if (c) m_state = 3;
           else if (m_cnt == T - 1) model_fail();
           else m_cnt++;
        3: if (!l) begin m_state = 0; m_retry = 0; end
           else if (!c) model_fail();
        default: ;
      endcase
    end
  endtask

  // Drive one cycle, predict, then compare after the edge
  task automatic step(input logic r, input logic l, input logic c);
    logic [8:0] exp_v;
    rst = r; lock = l; calib = c;
    model_edge(r, l, c);
    exp_q.push_back(model_outputs());
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    check("outputs", {23'd0, mig_rst, sys_rst, ready, error, retry, state}, {23'd0, exp_v});
  endtask

  task automatic run(input int n, input logic r, input logic l, input logic c);
    for (int i = 0; i < n; i++) step(r, l, c);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_mig"}, mig_rst, 0);
    check({tag, "_sys"}, sys_rst, 1);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_retry"}, retry, 0);
  endtask

  initial begin
    #1;
    check_reset_vals("powerup");
    @(posedge clk); #1;
    run(2, 1, 0, 0);
    check_reset_vals("reset");

    // Nominal bring-up: hold of H edges, then calibration completes
    step(0, 1, 0);
    run(H - 1, 0, 1, 0);
    check("hold_mig_low", mig_rst, 0);
    step(0, 1, 0);
    check("hold_mig_rise", mig_rst, 1);
    check("calib_state", state, 2);
    run(6, 0, 1, 0);
    step(0, 1, 1);
    check("ready", ready, 1);
    check("ready_sys", sys_rst, 0);
    check("ready_retry", retry, 0);
    run(3, 0, 1, 1);

    // Calibration lost while READY
    step(0, 1, 0);
    check("drop_state", state, 1);
    check("drop_retry", retry, 1);
    check("drop_ready", ready, 0);

    // Lock loss mid-HOLD, then full relock hold
    run(3, 0, 1, 0);
    step(0, 0, 0);
    check("lockloss_hold_state", state, 0);
    check("lockloss_hold_retry", retry, 0);
    step(0, 1, 0);
    run(H - 1, 0, 1, 0);
    check("relock_mig_low", mig_rst, 0);
    step(0, 1, 0);
    check("relock_mig_rise", mig_rst, 1);

    // Lock loss mid-CALIB and in READY
    run(4, 0, 1, 0);
    step(0, 0, 0);
    check("lockloss_calib_state", state, 0);
    check("lockloss_calib_mig", mig_rst, 0);
    step(0, 1, 0);
    run(H, 0, 1, 0);
    step(0, 1, 1);
    step(0, 0, 1);
    check("lockloss_ready_sys", sys_rst, 1);
    check("lockloss_ready_state", state, 0);

    // Completion on the final timeout cycle wins
    run(1, 1, 0, 0);
    step(0, 1, 0);
    run(H, 0, 1, 0);
    run(T - 1, 0, 1, 0);
    step(0, 1, 1);
    check("tie_ready", ready, 1);
    check("tie_retry", retry, 0);

    // Calibration never completes: retries then sticky ERROR
    run(1, 1, 0, 0);
    step(0, 1, 0);
    run(H + T, 0, 1, 0);
    check("retry1", retry, 1);
    check("retry1_mig", mig_rst, 0);
    run(H + T, 0, 1, 0);
    check("retry2", retry, 2);
    run(H + T - 1, 0, 1, 0);
    check("pre_error", error, 0);
    step(0, 1, 0);
    check("error", error, 1);
    check("error_state", state, 4);
    run(4, 0, 0, 1);
    run(4, 0, 1, 0);
    check("error_sticky", error, 1);
    step(1, 1, 0);
    check_reset_vals("rst_in_error");

    // Reset pulse during CALIB
    step(0, 1, 0);
    run(H + 3, 0, 1, 0);
    step(1, 1, 0);
    check_reset_vals("rst_in_calib");

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) != 0), ($urandom_range(0, 5) == 0) ? ~calib : calib);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule

// File: doc/mig_reset_sequencer.md
MIG_RESET_SEQUENCER -- requirements
Module: mig_reset_sequencer

Interface
REQ-001 SHALL have parameter COUNTER_WIDTH, default 24: width of the shared cycle counter.
REQ-002 SHALL have parameter HOLD_CYCLES, default 20000: MIG reset hold time (200 us at 100 MHz).
REQ-003 SHALL have parameter CALIB_TIMEOUT_CYCLES, default 10000000: calibration wait limit (100 ms at 100 MHz).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: number of re-hold attempts before ERROR.
REQ-005 SHALL have port i_Clock  in  1  sole clock; every flop is clocked on its rising edge.
REQ-006 SHALL have port i_Reset  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port i_Clk_Locked  in  1  MMCM lock indicator, already synchronous to i_Clock.
REQ-008 SHALL have port i_Calib_Complete  in  1  MIG init_calib_complete, already synchronous to i_Clock.
REQ-009 SHALL have port o_Mig_Reset  out  1  MIG sys_rst: 0 holds MIG in reset, 1 releases it.
REQ-010 SHALL have port o_System_Reset  out  1  active-high reset for memory-side logic, high until READY.
REQ-011 SHALL have port o_Ready  out  1  high only in READY.
REQ-012 SHALL have port o_Error  out  1  high only in ERROR.
REQ-013 SHALL have port o_Retry_Count  out  2  retries consumed since the last i_Reset or lock loss.
REQ-014 SHALL have port o_State  out  3  current state encoding, for debug.

Function
REQ-015 SHALL implement states IDLE, HOLD, CALIB, READY and ERROR; all outputs SHALL be registered.
REQ-016 In IDLE, i_Clk_Locked=1 at edge N SHALL enter HOLD with counter=0, so that o_Mig_Reset rises after edge N+HOLD_CYCLES.
REQ-017 HOLD SHALL keep o_Mig_Reset=0 and increment the counter; at counter==HOLD_CYCLES-1 it SHALL enter CALIB with counter=0 and o_Mig_Reset=1.
REQ-018 CALIB SHALL increment the counter; i_Calib_Complete=1 SHALL enter READY, and o_System_Reset=0 and o_Ready=1 SHALL take effect on that same edge.
REQ-019 CALIB timeout is counter==CALIB_TIMEOUT_CYCLES-1 with i_Calib_Complete=0.
REQ-020 On timeout with o_Retry_Count<MAX_RETRIES, the block SHALL increment o_Retry_Count, enter HOLD with counter=0, and drive o_Mig_Reset=0; otherwise it SHALL enter ERROR.
REQ-021 When i_Calib_Complete and the timeout occur on the same cycle, completion SHALL win.
REQ-022 In READY, i_Calib_Complete falling SHALL follow the timeout retry/ERROR rule of REQ-020 and SHALL drive o_System_Reset=1 and o_Ready=0.
REQ-023 i_Clk_Locked=0 in HOLD, CALIB or READY SHALL enter IDLE: o_Mig_Reset=0, o_System_Reset=1, o_Ready=0, counter=0, o_Retry_Count=0.
REQ-024 ERROR SHALL be sticky: o_Mig_Reset=0, o_System_Reset=1, o_Error=1, ignoring i_Clk_Locked and i_Calib_Complete until i_Reset.
REQ-025 The counter SHALL saturate and never wrap; o_Retry_Count SHALL never exceed MAX_RETRIES.
REQ-026 COUNTER_WIDTH SHALL hold max(HOLD_CYCLES, CALIB_TIMEOUT_CYCLES); this is checked by an elaboration-time assertion.

Reset
REQ-027 While i_Reset=1, the block SHALL be in IDLE with o_Mig_Reset=0, o_System_Reset=1, o_Ready=0, o_Error=0, o_Retry_Count=0 and counter=0.
REQ-028 i_Reset asserted in any state, including ERROR, SHALL return the block to IDLE on the next edge.
REQ-029 Power-up initial values SHALL equal the reset values.

Structure
REQ-030 State encodings (IDLE=0, HOLD=1, CALIB=2, READY=3, ERROR=4) and default timing constants SHALL live in the shared memory package/header.
REQ-031 The block SHALL be a single module with one state register, one shared counter and one retry counter; no sub-module.

Verification (HOLD_CYCLES=8, CALIB_TIMEOUT_CYCLES=16, MAX_RETRIES=2)
REQ-032 Lock at edge 5, calib at cycle 20 -> o_Mig_Reset rises after edge 13; o_Ready=1 and o_System_Reset=0 one edge after calib; o_Retry_Count=0.
REQ-033 Lock with calib never asserted -> two 8-cycle reset holds, o_Retry_Count 1 then 2, then o_Error=1 exactly 3×(8+16) cycles after lock; sticky until i_Reset.
REQ-034 Calib rises on the last timeout cycle of CALIB -> READY is entered, no retry is counted.
REQ-035 Lock drops mid-HOLD, mid-CALIB and in READY -> next edge IDLE, o_Mig_Reset=0, o_System_Reset=1, o_Retry_Count=0; relock restarts a full 8-cycle hold.
REQ-036 Calib drops in READY with o_Retry_Count=0 -> HOLD, o_Retry_Count=1, o_Ready=0.
REQ-037 i_Reset pulsed in ERROR and in CALIB -> all outputs equal their reset values on the next edge.
